mux_skid_stage: RTL

- Parametrised NUM_IN:1 selector of WIDTH-bit words with a registered output and a valid/ready handshake.
- Supersedes the bare 2:1 5-bit combinational select used for destination-register choice.
- Sits between pipeline stages, for example ID/EX rd/rt selection and forwarding-source selection.
- Carries stall (backpressure) and flush semantics.
- A 2-entry skid buffer keeps in_ready registered, so no combinational ready path crosses the stage.

---
 rtl/mips_pipe_pkg.sv | 22 ++
 rtl/mux_n.sv | 39 +++
 rtl/mux_skid_stage.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mips_pipe_pkg.sv
// -----------------------------------------------------------------------------
// mips_pipe_pkg
// Shared definitions for the pipeline selector stages.
//   skid_state_e  : occupancy of the two-entry skid stage (EMPTY / ONE / TWO)
//   num_in_legal  : elaboration-time check of the selector fan-in (2..16)
// -----------------------------------------------------------------------------
package mips_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  localparam int NUM_IN_MIN = 2;
  localparam int NUM_IN_MAX = 16;

  function automatic bit num_in_legal(input int n);
    return (n >= NUM_IN_MIN) && (n <= NUM_IN_MAX);
  endfunction

endpackage

// File: rtl/mux_n.sv
// -----------------------------------------------------------------------------
// mux_n
// Purely combinational NUM_IN:1 selector of WIDTH-bit words.
// Ports:
//   in_data  [NUM_IN*WIDTH] packed inputs, input k at [k*WIDTH +: WIDTH]
//   in_sel   [SEL_W]        index of the input to pass
//   out_data [WIDTH]        selected word, zero when in_sel is out of range
//   out_err                 in_sel >= NUM_IN (only possible for non-power-of-2)
// -----------------------------------------------------------------------------
module mux_n
  import mips_pipe_pkg::*;
#(
  parameter  int WIDTH  = 5,
  parameter  int NUM_IN = 2,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err
);

  if (!num_in_legal(NUM_IN)) begin : g_num_in_check
    $error("mux_n: NUM_IN=%0d outside legal range 2..16", NUM_IN);
  end

  // Default to the error result; a matching index overrides it.
  always_comb begin
    out_data = '0;
    out_err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (in_sel == SEL_W'(k)) begin
        out_data = in_data[k*WIDTH +: WIDTH];
        out_err  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_skid_stage.sv
// -----------------------------------------------------------------------------
// mux_skid_stage
// NUM_IN:1 word selector with a registered output, valid/ready handshake and a
// two-entry skid buffer so that in_ready comes straight from a flop.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_data, in_sel   packed candidate words and select index
//   in_valid/in_ready upstream handshake (in_ready registered)
//   flush             synchronous squash of every held word, highest priority
//   out_data/out_err  selected word and out-of-range flag
//   out_valid/out_ready downstream handshake
// -----------------------------------------------------------------------------
module mux_skid_stage
  import mips_pipe_pkg::*;
#(
  parameter  int WIDTH  = 5,
  parameter  int NUM_IN = 2,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  if (!num_in_legal(NUM_IN)) begin : g_num_in_check
    $error("mux_skid_stage: NUM_IN=%0d outside legal range 2..16", NUM_IN);
  end

  logic [WIDTH-1:0] sel_word;
  logic             sel_err;

  mux_n #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_mux (
    .in_data  (in_data),
    .in_sel   (in_sel),
    .out_data (sel_word),
    .out_err  (sel_err)
  );

  skid_state_e      state_q, state_d;
  logic             vld_q, vld_d;
  logic             rdy_q, rdy_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic             m_err_q, m_err_d;
  logic [WIDTH-1:0] s_data_q;
  logic             s_err_q;

  logic acc, pop;
  logic m_load, m_from_s, s_load;

  assign acc = in_valid & rdy_q;
  assign pop = vld_q & out_ready;

  always_comb begin
    state_d  = state_q;
    m_load   = 1'b0;
    m_from_s = 1'b0;
    s_load   = 1'b0;
    if (flush) begin
      // Data registers keep their contents; only occupancy is dropped.
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d = ST_ONE;
            m_load  = 1'b1;
          end
        end
        ST_ONE: begin
          if (acc && pop) begin
            m_load = 1'b1;
          end else if (acc) begin
            state_d = ST_TWO;
            s_load  = 1'b1;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only a pop can change anything.
          if (pop) begin
            state_d  = ST_ONE;
            m_load   = 1'b1;
            m_from_s = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Output flags are registered copies of the next-state decode so that
  // neither in_ready nor out_valid has logic after a flop.
  always_comb begin
    vld_d    = (state_d != ST_EMPTY);
    rdy_d    = (state_d != ST_TWO);
    m_data_d = m_from_s ? s_data_q : sel_word;
    m_err_d  = m_from_s ? s_err_q  : sel_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      vld_q    <= 1'b0;
      rdy_q    <= 1'b1;
      m_data_q <= '0;
      m_err_q  <= 1'b0;
      s_data_q <= '0;
      s_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      rdy_q   <= rdy_d;
      if (m_load) begin
        m_data_q <= m_data_d;
        m_err_q  <= m_err_d;
      end
      if (s_load) begin
        s_data_q <= sel_word;
        s_err_q  <= sel_err;
      end
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = vld_q;
  assign out_data  = m_data_q;
  assign out_err   = m_err_q;

endmodule
